pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port stall, input, 1, hold PC this cycle.
REQ-005 SHALL have port jump, input, 1, J-type jump (j) this cycle.
REQ-006 SHALL have port jal, input, 1, jump-and-link this cycle.
REQ-007 SHALL have port jr, input, 1, jump-register this cycle.
REQ-008 SHALL have port branch, input, 1, conditional branch instruction this cycle.
REQ-009 SHALL have port zero, input, 1, branch condition from ALU.
REQ-010 SHALL have port jaddr, input, 26, instruction index field [25:0].
REQ-011 SHALL have port boff, input, 16, branch offset field [15:0].
REQ-012 SHALL have port rs_val, input, 32, register value for jr.
REQ-013 SHALL have port pc, output, 32, current PC (registered).
REQ-014 SHALL have port pc_plus4, output, 32, pc + 4, combinational.
REQ-015 SHALL have port link_addr, output, 32, return address (pc + 4) for jal.
REQ-016 SHALL have port link_we, output, 1, register-31 write enable for jal.
REQ-017 SHALL have port halted, output, 1, sequencer in HALT state.
REQ-018 SHALL have port align_err, output, 1, sticky misaligned-target error.

Function
REQ-019 SHALL compute jump target as {pc_plus4[31:28], jaddr, 2'b00}.
REQ-020 SHALL compute branch target as pc_plus4 + ({{14{boff[15]}}, boff, 2'b00}), modulo 2^32 (wrap-around ignored).
REQ-021 SHALL select next PC with priority jr (rs_val) > jump|jal (jump target) > branch&zero (branch target) > pc_plus4.
REQ-022 SHALL implement FSM states RUN, STALL, HALT; next-PC register loads only in RUN when stall=0.
REQ-023 SHALL go RUN->STALL when stall=1, STALL->RUN when stall=0, holding pc throughout STALL; the control inputs sampled in the first cycle with stall=0 take effect.
REQ-024 SHALL go RUN->HALT when the selected next PC equals pc (jump-to-self) and stall=0; pc stays unchanged.
REQ-025 SHALL go RUN->HALT, set align_err, and hold pc when jr=1, stall=0 and rs_val[1:0]!=0.
REQ-026 SHALL leave HALT only through reset; all control inputs ignored in HALT.
REQ-027 SHALL drive link_we=1 only when jal=1, jr=0, state RUN and stall=0; link_addr=pc_plus4 at all times.
REQ-028 SHALL assert halted combinationally whenever state is HALT.
REQ-029 SHALL give one-cycle latency: target selected in cycle N appears on pc after edge N.

Reset
REQ-030 SHALL on reset assertion immediately set pc=RESET_PC, state=RUN, align_err=0, halted=0, link_we=0, independent of clk.
REQ-031 SHALL discard any in-flight stall or halt condition on reset mid-operation; first update after deassertion uses the inputs at that edge.

Structure
REQ-032 SHALL take state encoding (RUN=2'd0, STALL=2'd1, HALT=2'd2) and RESET_PC default from a shared package of processor constants.
REQ-033 SHALL instantiate one sub-module, jump_target, forming the 32-bit jump target from jaddr and pc_plus4[31:28].

Verification
REQ-034 SHALL verify reset: reset=1 mid-run at pc=0x40 -> pc=0x00000000 immediately, halted=0, align_err=0.
REQ-035 SHALL verify jump: pc=0x0040_0000, jump=1, jaddr=26'h0100010 -> next pc=0x0040_0040.
REQ-036 SHALL verify branch: pc=0x100, branch=1, zero=1, boff=16'hFFFE -> next pc=0x0FC; with zero=0 -> 0x104.
REQ-037 SHALL verify priority and link: jr=1, jal=1, rs_val=0x200 at pc=0x80 -> next pc=0x200, link_we=0; jal alone -> link_we=1, link_addr=0x84.
REQ-038 SHALL verify stall/halt: stall=1 for 3 cycles -> pc constant; jump-to-self -> halted=1 and pc frozen; jr with rs_val=0x202 -> align_err=1, halted=1.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared processor constants for the PC sequencer
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } seq_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    function automatic logic [31:0] branch_offset(input logic [15:0] boff);
        return {{14{boff[15]}}, boff, 2'b00};
    endfunction

endpackage

// File: rtl/jump_target.sv
// rtl/jump_target.sv - J-type target from instruction index and PC region
module jump_target (
    input  logic [25:0] jaddr_i,
    input  logic [3:0]  pc_region_i,
    output logic [31:0] target_o
);

    assign target_o = {pc_region_i, jaddr_i, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with jump/branch/jr select and RUN/STALL/HALT control
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump,
    input  logic        jal,
    input  logic        jr,
    input  logic        branch,
    input  logic        zero,
    input  logic [25:0] jaddr,
    input  logic [15:0] boff,
    input  logic [31:0] rs_val,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] link_addr,
    output logic        link_we,
    output logic        halted,
    output logic        align_err
);

    seq_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        align_err_q, align_err_d;

    logic [31:0] jump_tgt;
    logic [31:0] branch_tgt;
    logic [31:0] next_pc;
    logic        active;

    assign pc_plus4   = pc_q + PC_STEP;
    assign branch_tgt = pc_plus4 + branch_offset(boff);

    jump_target u_jump_target (
        .jaddr_i     (jaddr),
        .pc_region_i (pc_plus4[31:28]),
        .target_o    (jump_tgt)
    );

    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = rs_val;
        end else if (jump || jal) begin
            next_pc = jump_tgt;
        end else if (branch && zero) begin
            next_pc = branch_tgt;
        end
    end

    // The first stall-free cycle out of STALL executes its instruction just
    // like a RUN cycle, so no fetched control word is lost on release.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        align_err_d = align_err_q;
        active      = 1'b0;
        case (state_q)
            ST_RUN, ST_STALL: begin
                if (stall) begin
                    state_d = ST_STALL;
                end else begin
                    active = 1'b1;
                    if (jr && (rs_val[1:0] != 2'b00)) begin
                        state_d     = ST_HALT;
                        align_err_d = 1'b1;
                    end else if (next_pc == pc_q) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_RUN;
                        pc_d    = next_pc;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            align_err_q <= align_err_d;
        end
    end

    assign pc        = pc_q;
    assign link_addr = pc_plus4;
    assign link_we   = active && jal && !jr;
    assign halted    = (state_q == ST_HALT);
    assign align_err = align_err_q;

endmodule
